// File: rtl/hs_block_ram_dp_pkg.sv
// hs_block_ram_dp_pkg: shared constants for the dual-port block RAM (max read latency, credit counter width)
package hs_block_ram_dp_pkg;
  localparam int RLAT_MAX = 3;
  localparam int CW = $clog2(RLAT_MAX + 2);
endpackage

// File: rtl/hs_block_ram_dp_rsp_queue.sv
// hs_block_ram_dp_rsp_queue: per-port fall-through response fifo (depth rlat+1) plus read-credit counter driving req_ready
module hs_block_ram_dp_rsp_queue
  import hs_block_ram_dp_pkg::*;
#(
  parameter int dbits = 32,
  parameter int rlat = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_acc,
  input  logic             push,
  input  logic [dbits-1:0] push_data,
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [dbits-1:0] rdata
);
  localparam logic [CW-1:0] depth = CW'(rlat + 1);
  logic [CW-1:0] cnt, occ;
  logic [1:0] wp, rp;
  logic [dbits-1:0] q [RLAT_MAX+1];
  logic empty, pop, store, deq;
  assign empty = occ == '0;
  assign rsp_valid = !rst && (!empty || push);
  assign rdata = empty ? push_data : q[rp];
  assign pop = rsp_valid && rsp_ready;
  assign store = push && !(empty && pop);
  assign deq = pop && !empty;
  assign req_ready = !rst && cnt < depth;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      occ <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      cnt <= cnt + CW'(rd_acc) - CW'(pop);
      occ <= occ + CW'(store) - CW'(deq);
      if (store) begin
        q[wp] <= push_data;
        wp <= wp == 2'(rlat) ? '0 : wp + 2'd1;
      end
      if (deq) rp <= rp == 2'(rlat) ? '0 : rp + 2'd1;
    end
  end
endmodule

// File: rtl/hs_block_ram_dp.sv
// hs_block_ram_dp: true dual-port byte-enabled block RAM with valid/ready request/response handshakes on ports a and b
module hs_block_ram_dp
  import hs_block_ram_dp_pkg::*;
#(
  parameter int abits = 8,
  parameter int dbytes = 4,
  parameter int blen = 8,
  parameter int rlat = 1,
  parameter bit write_first = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_req_valid,
  output logic                   a_req_ready,
  input  logic [dbytes-1:0]      a_we,
  input  logic [abits-1:0]       a_addr,
  input  logic [dbytes*blen-1:0] a_wdata,
  output logic                   a_rsp_valid,
  input  logic                   a_rsp_ready,
  output logic [dbytes*blen-1:0] a_rdata,
  input  logic                   b_req_valid,
  output logic                   b_req_ready,
  input  logic [dbytes-1:0]      b_we,
  input  logic [abits-1:0]       b_addr,
  input  logic [dbytes*blen-1:0] b_wdata,
  output logic                   b_rsp_valid,
  input  logic                   b_rsp_ready,
  output logic [dbytes*blen-1:0] b_rdata
);
  localparam int dbits = dbytes * blen;
  logic [dbits-1:0] mem [2**abits];
  logic [1:0] wa;
  logic rv [2], sr [2], rr [2], sv [2];
  logic [dbytes-1:0] we [2];
  logic [abits-1:0] ad [2];
  logic [dbits-1:0] wd [2], rd [2];
  assign rv = '{a_req_valid, b_req_valid};
  assign sr = '{a_rsp_ready, b_rsp_ready};
  assign we = '{a_we, b_we};
  assign ad = '{a_addr, b_addr};
  assign wd = '{a_wdata, b_wdata};
  assign a_req_ready = rr[0];
  assign b_req_ready = rr[1];
  assign a_rsp_valid = sv[0];
  assign b_rsp_valid = sv[1];
  assign a_rdata = rd[0];
  assign b_rdata = rd[1];
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--)
      for (int i = 0; i < dbytes; i++)
        if (wa[p] && we[p][i]) mem[ad[p]][i*blen +: blen] <= wd[p][i*blen +: blen];
  end
  for (genvar g = 0; g < 2; g++) begin : g_port
    logic ra;
    logic [dbits-1:0] word;
    logic [rlat-1:0] pv;
    logic [dbits-1:0] pd [rlat];
    assign wa[g] = rv[g] && rr[g] && |we[g];
    assign ra = rv[g] && rr[g] && !(|we[g]);
    always_comb begin
      word = mem[ad[g]];
      for (int i = 0; i < dbytes; i++)
        if (write_first && wa[1-g] && we[1-g][i] && ad[1-g] == ad[g]) word[i*blen +: blen] = wd[1-g][i*blen +: blen];
    end
    always_ff @(posedge clk) begin
      for (int i = rlat - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= ra;
      pd[0] <= word;
      if (rst) pv <= '0;
    end
    hs_block_ram_dp_rsp_queue #(.dbits(dbits), .rlat(rlat)) u_q (
      .clk(clk),
      .rst(rst),
      .rd_acc(ra),
      .push(pv[rlat-1]),
      .push_data(pd[rlat-1]),
      .req_ready(rr[g]),
      .rsp_valid(sv[g]),
      .rsp_ready(sr[g]),
      .rdata(rd[g])
    );
  end
endmodule

// File: tb/tb_hs_block_ram_dp.sv
// tb_hs_block_ram_dp: directed plus random checks of the dual-port RAM against an accept-time/in-order reference model
module tb_hs_block_ram_dp;
  localparam int RLAT = 3;
  localparam bit WF = 1'b0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv [2], sr [2], qr [2], sv [2];
  logic [3:0] we [2];
  logic [7:0] ad [2];
  logic [31:0] wd [2], rd [2];
  logic w_rv [2], w_sr [2], w_qr [2], w_sv [2];
  logic [3:0] w_we [2];
  logic [7:0] w_ad [2];
  logic [31:0] w_wd [2], w_rd [2];
  int n_chk = 0, n_fail = 0, cyc = 0, b_acc = 0;
  logic [31:0] mm [256];
  logic [31:0] ed [2][8];
  int et [2][8];
  int hd [2], tl [2];
  hs_block_ram_dp #(.abits(8), .dbytes(4), .blen(8), .rlat(RLAT), .write_first(WF)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(rv[0]), .a_req_ready(qr[0]), .a_we(we[0]), .a_addr(ad[0]), .a_wdata(wd[0]),
    .a_rsp_valid(sv[0]), .a_rsp_ready(sr[0]), .a_rdata(rd[0]),
    .b_req_valid(rv[1]), .b_req_ready(qr[1]), .b_we(we[1]), .b_addr(ad[1]), .b_wdata(wd[1]),
    .b_rsp_valid(sv[1]), .b_rsp_ready(sr[1]), .b_rdata(rd[1])
  );
  hs_block_ram_dp #(.abits(8), .dbytes(4), .blen(8), .rlat(1), .write_first(1'b1)) u_wf (
    .clk(clk), .rst(rst),
    .a_req_valid(w_rv[0]), .a_req_ready(w_qr[0]), .a_we(w_we[0]), .a_addr(w_ad[0]), .a_wdata(w_wd[0]),
    .a_rsp_valid(w_sv[0]), .a_rsp_ready(w_sr[0]), .a_rdata(w_rd[0]),
    .b_req_valid(w_rv[1]), .b_req_ready(w_qr[1]), .b_we(w_we[1]), .b_addr(w_ad[1]), .b_wdata(w_wd[1]),
    .b_rsp_valid(w_sv[1]), .b_rsp_ready(w_sr[1]), .b_rdata(w_rd[1])
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0;
      we[p] = 4'h0;
      ad[p] = 8'h00;
      wd[p] = 32'h0;
    end
  endtask
  task automatic req(input int p, input logic [3:0] w, input logic [7:0] a, input logic [31:0] d);
    rv[p] = 1'b1;
    we[p] = w;
    ad[p] = a;
    wd[p] = d;
  endtask
  task automatic step();
    logic acc [2], pop [2];
    logic rdy, ev;
    logic [31:0] d;
    #1;
    for (int p = 0; p < 2; p++) begin
      rdy = !rst && (tl[p] - hd[p] < RLAT + 1);
      ev = !rst && tl[p] != hd[p] && cyc >= et[p][hd[p] % 8] + RLAT;
      chk($sformatf("req_ready[%0d] cyc %0d", p, cyc), 32'(qr[p]), 32'(rdy));
      chk($sformatf("rsp_valid[%0d] cyc %0d", p, cyc), 32'(sv[p]), 32'(ev));
      if (ev) chk($sformatf("rdata[%0d] cyc %0d", p, cyc), rd[p], ed[p][hd[p] % 8]);
      acc[p] = rv[p] && rdy;
      pop[p] = ev && sr[p];
    end
    if (rv[1] && qr[1] && we[1] == 4'h0) b_acc++;
    for (int p = 0; p < 2; p++)
      if (acc[p] && we[p] == 4'h0) begin
        d = mm[ad[p]];
        for (int i = 0; i < 4; i++)
          if (WF && acc[1-p] && we[1-p][i] && ad[1-p] == ad[p]) d[i*8 +: 8] = wd[1-p][i*8 +: 8];
        ed[p][tl[p] % 8] = d;
        et[p][tl[p] % 8] = cyc;
        tl[p]++;
      end
    for (int p = 1; p >= 0; p--)
      if (acc[p])
        for (int i = 0; i < 4; i++)
          if (we[p][i]) mm[ad[p]][i*8 +: 8] = wd[p][i*8 +: 8];
    for (int p = 0; p < 2; p++) begin
      if (pop[p]) hd[p]++;
      if (rst) begin
        hd[p] = 0;
        tl[p] = 0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  initial begin
    idle();
    for (int p = 0; p < 2; p++) begin
      sr[p] = 1'b1;
      hd[p] = 0;
      tl[p] = 0;
      w_rv[p] = 1'b0;
      w_we[p] = 4'h0;
      w_ad[p] = 8'h00;
      w_wd[p] = 32'h0;
      w_sr[p] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int k = 0; k < 128; k++) begin
      req(0, 4'hF, 8'(2 * k), 32'h0);
      req(1, 4'hF, 8'(2 * k + 1), 32'h0);
      step();
    end
    idle();
    req(0, 4'hF, 8'h10, 32'hDEADBEEF);
    step();
    req(0, 4'h0, 8'h10, 32'h0);
    step();
    idle();
    repeat (RLAT + 1) step();
    req(0, 4'hF, 8'h20, 32'h11223344);
    req(1, 4'h0, 8'h20, 32'h0);
    step();
    idle();
    repeat (RLAT + 1) step();
    req(0, 4'b0011, 8'h30, 32'hAAAAAAAA);
    req(1, 4'b0110, 8'h30, 32'hBBBBBBBB);
    step();
    idle();
    req(0, 4'h0, 8'h30, 32'h0);
    step();
    idle();
    repeat (RLAT + 1) step();
    for (int k = 0; k < 8; k++) begin
      req(0, 4'hF, 8'(8'h40 + k), 32'hC0DE0000 + 32'(k));
      step();
    end
    idle();
    sr[1] = 1'b0;
    b_acc = 0;
    for (int k = 0; k < 8; k++) begin
      req(1, 4'h0, 8'(8'h40 + k), 32'h0);
      step();
    end
    idle();
    chk("b reads accepted while stalled", 32'(b_acc), 32'd4);
    sr[1] = 1'b1;
    repeat (RLAT + 3) step();
    req(0, 4'h0, 8'h10, 32'h0);
    step();
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (RLAT + 2) step();
    req(0, 4'h0, 8'h10, 32'h0);
    step();
    idle();
    repeat (RLAT + 1) step();
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        rv[p] = 1'($urandom);
        we[p] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
        ad[p] = 8'($urandom % 16);
        wd[p] = $urandom;
        sr[p] = ($urandom % 4) != 0;
      end
      step();
    end
    idle();
    sr[0] = 1'b1;
    sr[1] = 1'b1;
    repeat (RLAT + 6) step();
    w_rv[0] = 1'b1;
    w_we[0] = 4'hF;
    w_ad[0] = 8'h20;
    w_wd[0] = 32'h11223344;
    w_rv[1] = 1'b1;
    w_we[1] = 4'h0;
    w_ad[1] = 8'h20;
    #1;
    chk("wf req_ready both", 32'(w_qr[0] && w_qr[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    w_rv[0] = 1'b0;
    w_rv[1] = 1'b0;
    #1;
    chk("wf b rsp_valid", 32'(w_sv[1]), 32'd1);
    chk("wf b rdata", w_rd[1], 32'h11223344);
    chk("wf a no rsp", 32'(w_sv[0]), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
